// File: rtl/rst_sequencer_if.sv
// Signal bundle between the reset sequencer and its surroundings: PLL lock and
// software reset requests in, sequenced reset/status outputs back.
interface rst_sequencer_if;
    logic       i_pll_locked;
    logic       i_sw_rst;
    logic       o_rst_dbg;
    logic       o_rst_sys;
    logic       o_ready;
    logic [7:0] o_lock_lost_cnt;
    logic [2:0] o_state;

    modport master (
        output i_pll_locked,
        output i_sw_rst,
        input  o_rst_dbg,
        input  o_rst_sys,
        input  o_ready,
        input  o_lock_lost_cnt,
        input  o_state
    );

    modport slave (
        input  i_pll_locked,
        input  i_sw_rst,
        output o_rst_dbg,
        output o_rst_sys,
        output o_ready,
        output o_lock_lost_cnt,
        output o_state
    );
endinterface

// File: rtl/rst_sequencer.sv
// Power-up reset sequencer: waits for a stable PLL lock, releases the debug reset,
// then the system reset, and handles software reset pulses and lock loss.
module rst_sequencer #(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned LOCK_CYCLES       = 16,
    parameter int unsigned DBG_TO_SYS_CYCLES = 4,
    parameter int unsigned SW_RST_CYCLES     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rst_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_DBG_UP    = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_RST    = 3'd4
    } state_t;

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] DBG_LAST  = 16'(DBG_TO_SYS_CYCLES - 1);
    localparam logic [15:0] SW_LAST   = 16'(SW_RST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lock_s;
    state_t                 state_r;
    logic [15:0]            cnt_r;
    logic                   rst_dbg_r;
    logic                   rst_sys_r;
    logic                   ready_r;
    logic [7:0]             lost_cnt_r;

    // Output levels {dbg, sys, ready} that belong to a given state.
    function automatic logic [2:0] out_decode(input state_t st);
        logic [2:0] res;
        case (st)
            ST_WAIT_LOCK: res = 3'b110;
            ST_STABLE:    res = 3'b110;
            ST_DBG_UP:    res = 3'b010;
            ST_RUN:       res = 3'b001;
            ST_SW_RST:    res = 3'b010;
            default:      res = 3'b110;
        endcase
        return res;
    endfunction

    assign lock_s = sync_r[SYNC_STAGES-1];

    // Lock flag synchronizer chain; only its last stage is trusted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.i_pll_locked};
        end
    end

    // Sequencer FSM; outputs are loaded on the same edge as the state they decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_WAIT_LOCK;
            cnt_r      <= 16'd0;
            rst_dbg_r  <= 1'b1;
            rst_sys_r  <= 1'b1;
            ready_r    <= 1'b0;
            lost_cnt_r <= 8'd0;
        end else if ((state_r != ST_WAIT_LOCK) && !lock_s) begin
            // Lock loss overrides software requests and count expiry.
            state_r                           <= ST_WAIT_LOCK;
            cnt_r                             <= 16'd0;
            {rst_dbg_r, rst_sys_r, ready_r}   <= out_decode(ST_WAIT_LOCK);
            if (lost_cnt_r != 8'hFF) begin
                lost_cnt_r <= lost_cnt_r + 8'd1;
            end else begin
                lost_cnt_r <= lost_cnt_r;
            end
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_r                         <= ST_STABLE;
                        cnt_r                           <= 16'd0;
                        {rst_dbg_r, rst_sys_r, ready_r} <= out_decode(ST_STABLE);
                    end
                end
                ST_STABLE: begin
                    if (cnt_r == LOCK_LAST) begin
                        state_r                         <= ST_DBG_UP;
                        cnt_r                           <= 16'd0;
                        {rst_dbg_r, rst_sys_r, ready_r} <= out_decode(ST_DBG_UP);
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_DBG_UP: begin
                    if (cnt_r == DBG_LAST) begin
                        state_r                         <= ST_RUN;
                        cnt_r                           <= 16'd0;
                        {rst_dbg_r, rst_sys_r, ready_r} <= out_decode(ST_RUN);
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (bus.i_sw_rst) begin
                        state_r                         <= ST_SW_RST;
                        cnt_r                           <= 16'd0;
                        {rst_dbg_r, rst_sys_r, ready_r} <= out_decode(ST_SW_RST);
                    end
                end
                ST_SW_RST: begin
                    // Further requests here are ignored so the pulse length stays fixed.
                    if (cnt_r == SW_LAST) begin
                        state_r                         <= ST_RUN;
                        cnt_r                           <= 16'd0;
                        {rst_dbg_r, rst_sys_r, ready_r} <= out_decode(ST_RUN);
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r                         <= ST_WAIT_LOCK;
                    cnt_r                           <= 16'd0;
                    {rst_dbg_r, rst_sys_r, ready_r} <= out_decode(ST_WAIT_LOCK);
                end
            endcase
        end
    end

    assign bus.o_rst_dbg       = rst_dbg_r;
    assign bus.o_rst_sys       = rst_sys_r;
    assign bus.o_ready         = ready_r;
    assign bus.o_lock_lost_cnt = lost_cnt_r;
    assign bus.o_state         = state_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: the stimulus queues expected outputs per clock
// edge and an independent negedge monitor pops and compares them.
module tb_rst_sequencer;

    typedef struct {
        int         at;
        logic [2:0] st;
        logic       dbg;
        logic       sys;
        logic       rdy;
        logic [7:0] lost;
        string      name;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    int     checks   = 0;
    int     failures = 0;
    int     now      = 0;
    int     mon_edge = 0;
    exp_t   exp_q[$];
    exp_t   cur;

    rst_sequencer_if bus_if ();

    rst_sequencer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic expect_at(input int at, input logic [2:0] st, input logic dbg,
                             input logic sys, input logic rdy, input logic [7:0] lost,
                             input string name);
        exp_t e;
        e.at = at; e.st = st; e.dbg = dbg; e.sys = sys; e.rdy = rdy; e.lost = lost; e.name = name;
        exp_q.push_back(e);
    endtask

    // Advance to 2 time units after posedge number e (edges counted from 1).
    task automatic goto(input int e);
        repeat (e - now) @(posedge clk);
        #2;
        now = e;
    endtask

    // Monitor: compare every queued expectation at the negedge following its edge.
    always @(negedge clk) begin
        mon_edge = mon_edge + 1;
        while (exp_q.size() > 0 && exp_q[0].at <= mon_edge) begin
            cur = exp_q.pop_front();
            checks = checks + 1;
            if (cur.at != mon_edge ||
                bus_if.o_state !== cur.st || bus_if.o_rst_dbg !== cur.dbg ||
                bus_if.o_rst_sys !== cur.sys || bus_if.o_ready !== cur.rdy ||
                bus_if.o_lock_lost_cnt !== cur.lost) begin
                failures = failures + 1;
                $display("FAIL %s edge=%0d got st=%0d dbg=%0b sys=%0b rdy=%0b lost=%0d exp st=%0d dbg=%0b sys=%0b rdy=%0b lost=%0d",
                         cur.name, cur.at, bus_if.o_state, bus_if.o_rst_dbg, bus_if.o_rst_sys,
                         bus_if.o_ready, bus_if.o_lock_lost_cnt, cur.st, cur.dbg, cur.sys,
                         cur.rdy, cur.lost);
            end
        end
    end

    initial begin
        #100000;
        failures = failures + 1;
        $display("FAIL watchdog time limit reached got running required finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        int lost_exp;
        rst = 1'b1;
        bus_if.i_pll_locked = 1'b0;
        bus_if.i_sw_rst     = 1'b0;

        // Power-up: reset for edges 1..3, lock sampled from edge 10.
        expect_at(1,  3'd0, 1'b1, 1'b1, 1'b0, 8'd0, "reset_e1");
        expect_at(3,  3'd0, 1'b1, 1'b1, 1'b0, 8'd0, "reset_e3");
        expect_at(11, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0, "pu_wait_e11");
        expect_at(12, 3'd1, 1'b1, 1'b1, 1'b0, 8'd0, "pu_stable_e12");
        expect_at(27, 3'd1, 1'b1, 1'b1, 1'b0, 8'd0, "pu_stable_e27");
        expect_at(28, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0, "pu_dbgup_e28");
        expect_at(31, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0, "pu_dbgup_e31");
        expect_at(32, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0, "pu_run_e32");
        goto(3);
        rst = 1'b0;
        goto(9);
        bus_if.i_pll_locked = 1'b1;

        // Software reset pulse with a second request inside the pulse.
        goto(32);
        expect_at(33, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, "sw_enter_e33");
        expect_at(35, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, "sw_hold_e35");
        expect_at(36, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, "sw_hold_e36");
        expect_at(40, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, "sw_last_e40");
        expect_at(41, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0, "sw_run_e41");
        expect_at(42, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0, "sw_run_e42");
        bus_if.i_sw_rst = 1'b1;
        goto(33);
        bus_if.i_sw_rst = 1'b0;
        goto(34);
        bus_if.i_sw_rst = 1'b1;
        goto(35);
        bus_if.i_sw_rst = 1'b0;

        // Lock loss inside SW_RST while the request is still held.
        goto(42);
        expect_at(43, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, "swloss_enter_e43");
        expect_at(46, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, "swloss_hold_e46");
        expect_at(47, 3'd0, 1'b1, 1'b1, 1'b0, 8'd1, "swloss_wait_e47");
        bus_if.i_sw_rst = 1'b1;
        goto(44);
        bus_if.i_pll_locked = 1'b0;
        goto(47);
        bus_if.i_sw_rst = 1'b0;

        // Glitchy lock: 10 synced high cycles, then a full stable sequence.
        expect_at(51, 3'd1, 1'b1, 1'b1, 1'b0, 8'd1, "glitch_stable_e51");
        expect_at(55, 3'd1, 1'b1, 1'b1, 1'b0, 8'd1, "glitch_stable_e55");
        expect_at(60, 3'd1, 1'b1, 1'b1, 1'b0, 8'd1, "glitch_stable_e60");
        expect_at(61, 3'd0, 1'b1, 1'b1, 1'b0, 8'd2, "glitch_wait_e61");
        expect_at(64, 3'd0, 1'b1, 1'b1, 1'b0, 8'd2, "relock_wait_e64");
        expect_at(65, 3'd1, 1'b1, 1'b1, 1'b0, 8'd2, "relock_stable_e65");
        expect_at(80, 3'd1, 1'b1, 1'b1, 1'b0, 8'd2, "relock_stable_e80");
        expect_at(81, 3'd2, 1'b0, 1'b1, 1'b0, 8'd2, "relock_dbgup_e81");
        expect_at(84, 3'd2, 1'b0, 1'b1, 1'b0, 8'd2, "relock_dbgup_e84");
        expect_at(85, 3'd3, 1'b0, 1'b0, 1'b1, 8'd2, "relock_run_e85");
        goto(48);
        bus_if.i_pll_locked = 1'b1;
        goto(58);
        bus_if.i_pll_locked = 1'b0;
        goto(62);
        bus_if.i_pll_locked = 1'b1;

        // Lock loss in RUN, relock, then reset in DBG_UP at count 2.
        expect_at(88,  3'd0, 1'b1, 1'b1, 1'b0, 8'd3, "runloss_wait_e88");
        expect_at(91,  3'd1, 1'b1, 1'b1, 1'b0, 8'd3, "rst_path_stable_e91");
        expect_at(107, 3'd2, 1'b0, 1'b1, 1'b0, 8'd3, "rst_path_dbgup_e107");
        expect_at(109, 3'd2, 1'b0, 1'b1, 1'b0, 8'd3, "rst_path_dbgup_e109");
        expect_at(110, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0, "midcount_reset_e110");
        expect_at(112, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0, "sync_cleared_e112");
        expect_at(113, 3'd1, 1'b1, 1'b1, 1'b0, 8'd0, "post_reset_stable_e113");
        goto(85);
        bus_if.i_pll_locked = 1'b0;
        goto(88);
        bus_if.i_pll_locked = 1'b1;
        goto(109);
        rst = 1'b1;
        goto(110);
        rst = 1'b0;
        goto(113);

        // Saturation: 300 lock-loss events, 8 cycles each.
        for (int i = 1; i <= 300; i++) begin
            n = now;
            lost_exp = (i > 255) ? 255 : i;
            if (i == 1 || i == 2 || i == 254 || i == 255 || i == 256 || i == 300)
                expect_at(n + 8, 3'd0, 1'b1, 1'b1, 1'b0, 8'(lost_exp),
                          $sformatf("sat_event_%0d", i));
            bus_if.i_pll_locked = 1'b1;
            goto(n + 4);
            bus_if.i_pll_locked = 1'b0;
            goto(n + 8);
        end

        goto(now + 2);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL queue_drained got pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
